// File: rtl/usr_pkg.sv
// Shared types and width helpers for the universal shift register.
package usr_pkg;

    // Operation select encoding presented on the mode input.
    typedef enum logic [1:0] {
        USR_HOLD = 2'b00,
        USR_SHL  = 2'b01,
        USR_SHR  = 2'b10,
        USR_LOAD = 2'b11
    } usr_mode_t;

    // Legal register width range.
    localparam int unsigned USR_WIDTH_MIN = 2;
    localparam int unsigned USR_WIDTH_MAX = 64;

    // Bits needed to hold a count from 0 up to and including max.
    function automatic int unsigned usr_cnt_w(input int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage : usr_pkg

// File: rtl/usr_sat_cnt.sv
// Saturating up-counter with synchronous clear; full flags the terminal value.
module usr_sat_cnt
    import usr_pkg::*;
#(
    parameter int unsigned MAX = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         inc,
    output logic [usr_cnt_w(MAX)-1:0]    cnt,
    output logic                         full
);

    localparam int unsigned CNT_W = usr_cnt_w(MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;

    // Next count: clear wins over increment; increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_W'(MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        full_d = (cnt_d == CNT_W'(MAX));
    end

    // Count and full flag registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign cnt  = cnt_q;
    assign full = full_q;

endmodule : usr_sat_cnt

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, parallel load, with a
// saturating count of shifts since the last load or reset.
// Optional feature: define USR_ROTATE_EN to add the rot input, which turns
// shifts into rotates that leave the shift count untouched.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         sin_l,
    input  logic                         sin_r,
`ifdef USR_ROTATE_EN
    input  logic                         rot,
`endif
    input  logic [WIDTH-1:0]             d,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_l,
    output logic                         sout_r,
    output logic [usr_cnt_w(WIDTH)-1:0]  cnt,
    output logic                         full
);

    // Reject unsupported widths at elaboration.
    if ((WIDTH < USR_WIDTH_MIN) || (WIDTH > USR_WIDTH_MAX)) begin : g_bad_width
        $error("univ_shift_reg: WIDTH %0d out of range", WIDTH);
    end

    logic [WIDTH-1:0] q_q, q_d;
    usr_mode_t        mode_e;
    logic             rot_on;
    logic             cnt_clear;
    logic             cnt_inc;

    assign mode_e = usr_mode_t'(mode);

`ifdef USR_ROTATE_EN
    assign rot_on = rot;
`else
    assign rot_on = 1'b0;
`endif

    // Next register value and counter controls from mode; en gates everything.
    always_comb begin
        q_d       = q_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        if (en) begin
            case (mode_e)
                USR_HOLD: begin
                    q_d = q_q;
                end
                USR_SHL: begin
                    if (rot_on) begin
                        q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    end else begin
                        q_d     = {q_q[WIDTH-2:0], sin_l};
                        cnt_inc = 1'b1;
                    end
                end
                USR_SHR: begin
                    if (rot_on) begin
                        q_d = {q_q[0], q_q[WIDTH-1:1]};
                    end else begin
                        q_d     = {sin_r, q_q[WIDTH-1:1]};
                        cnt_inc = 1'b1;
                    end
                end
                USR_LOAD: begin
                    q_d       = d;
                    cnt_clear = 1'b1;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    // Data register, synchronous reset to RESET_VAL.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    usr_sat_cnt #(
        .MAX   (WIDTH)
    ) u_sat_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .cnt   (cnt),
        .full  (full)
    );

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, RESET_VAL=0): arithmetic reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       sin_l = 1'b0;
    logic       sin_r = 1'b0;
    logic       rot = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] cnt;
    logic       full;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers.
    int mq = 0;
    int mcnt = 0;
    bit mvalid = 1'b0;

    univ_shift_reg #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .mode   (mode),
        .sin_l  (sin_l),
        .sin_r  (sin_r),
`ifdef USR_ROTATE_EN
        .rot    (rot),
`endif
        .d      (d),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .cnt    (cnt),
        .full   (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model update at each rising edge from the inputs the DUT sees.
    always @(posedge clk) begin
        bit rot_now;
`ifdef USR_ROTATE_EN
        rot_now = rot;
`else
        rot_now = 1'b0;
`endif
        if (reset) begin
            mq     = 0;
            mcnt   = 0;
            mvalid = 1'b1;
        end else if (en) begin
            case (mode)
                2'b01: begin
                    if (rot_now) mq = (mq * 2) % 256 + mq / 128;
                    else begin
                        mq   = (mq * 2) % 256 + int'(sin_l);
                        mcnt = (mcnt < 8) ? mcnt + 1 : 8;
                    end
                end
                2'b10: begin
                    if (rot_now) mq = mq / 2 + (mq % 2) * 128;
                    else begin
                        mq   = mq / 2 + int'(sin_r) * 128;
                        mcnt = (mcnt < 8) ? mcnt + 1 : 8;
                    end
                end
                2'b11: begin
                    mq   = int'(d);
                    mcnt = 0;
                end
                default: ;
            endcase
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (mvalid) begin
            check("model_q",      64'(q),      64'(mq));
            check("model_cnt",    64'(cnt),    64'(mcnt));
            check("model_full",   64'(full),   64'(mcnt == 8));
            check("model_sout_l", 64'(sout_l), 64'(mq / 128));
            check("model_sout_r", 64'(sout_r), 64'(mq % 2));
        end
    end

    // Apply one cycle of inputs, then return just after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic [1:0] m,
                       input logic sl, input logic sr, input logic [7:0] dv);
        reset = r;
        en    = e;
        mode  = m;
        sin_l = sl;
        sin_r = sr;
        d     = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;

        // Reset held two cycles while a load is requested.
        cyc(1, 1, 2'b11, 0, 0, 8'hA5);
        cyc(1, 1, 2'b11, 0, 0, 8'hA5);
        check("rst_q",    64'(q),    64'h00);
        check("rst_cnt",  64'(cnt),  64'd0);
        check("rst_full", 64'(full), 64'd0);

        // Load A5 then shift left with sin_l=1.
        cyc(0, 1, 2'b11, 0, 0, 8'hA5);
        check("load_q",      64'(q),      64'hA5);
        check("load_sout_l", 64'(sout_l), 64'd1);
        check("load_sout_r", 64'(sout_r), 64'd1);
        cyc(0, 1, 2'b01, 1, 0, 8'h00);
        check("shl_q",   64'(q),   64'h4B);
        check("shl_cnt", 64'(cnt), 64'd1);

        // Fill with ones by right shifts and saturate.
        cyc(0, 1, 2'b11, 0, 0, 8'h00);
        check("fill_start_cnt", 64'(cnt), 64'd0);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 1, 2'b10, 0, 1, 8'h00);
            check("fill_cnt",  64'(cnt),  64'((i < 8) ? i : 8));
            check("fill_full", 64'(full), 64'(i >= 8));
        end
        check("fill_q", 64'(q), 64'hFF);

        // Disabled cycles keep the saturated state.
        repeat (2) cyc(0, 0, 2'b11, 1, 0, 8'h12);
        check("sat_hold_cnt",  64'(cnt),  64'd8);
        check("sat_hold_full", 64'(full), 64'd1);

        // Enable and hold.
        cyc(0, 1, 2'b11, 0, 0, 8'h3C);
        check("full_clr_on_load", 64'(full), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 2'b01, 1, 1, 8'hFF);
            check("en0_q",   64'(q),   64'h3C);
            check("en0_cnt", 64'(cnt), 64'd0);
        end
        cyc(0, 1, 2'b00, 1, 1, 8'hFF);
        check("hold_q",   64'(q),   64'h3C);
        check("hold_cnt", 64'(cnt), 64'd0);

        // Reset priority mid-sequence.
        cyc(0, 1, 2'b11, 0, 0, 8'h0F);
        repeat (4) cyc(0, 1, 2'b01, 0, 0, 8'h00);
        check("pre_rst_q",   64'(q),   64'hF0);
        check("pre_rst_cnt", 64'(cnt), 64'd4);
        cyc(1, 1, 2'b11, 0, 0, 8'hFF);
        check("rstpri_q",    64'(q),    64'h00);
        check("rstpri_cnt",  64'(cnt),  64'd0);
        check("rstpri_full", 64'(full), 64'd0);

`ifdef USR_ROTATE_EN
        cyc(0, 1, 2'b11, 0, 0, 8'h81);
        rot = 1'b1;
        cyc(0, 1, 2'b01, 0, 0, 8'h00);
        check("rotl_q",   64'(q),   64'h03);
        check("rotl_cnt", 64'(cnt), 64'd0);
        cyc(0, 1, 2'b10, 0, 0, 8'h00);
        check("rotr_q",   64'(q),   64'h81);
        check("rotr_cnt", 64'(cnt), 64'd0);
        cyc(0, 1, 2'b11, 0, 0, 8'h5A);
        check("rot_load_q", 64'(q), 64'h5A);
        rot = 1'b0;
`endif

        // Mixed directed pattern, checked by the model each cycle.
        for (int i = 0; i < 40; i++) begin
            logic [1:0] m;
            logic [7:0] dv;
            m  = 2'((i * 7 + i / 3) % 4);
            dv = 8'((i * 37 + 11) % 256);
            cyc((i == 29), (i % 5 != 4), m, logic'(i % 2), logic'((i / 2) % 2), dv);
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_univ_shift_reg

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits, legal range 2..64.
REQ-002 Parameter RESET_VAL, default 0: value loaded into q on reset, WIDTH bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  clock enable; when 0, all state holds.
REQ-006 mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 sin_l  input  1  serial input entering bit 0 on shift left.
REQ-008 sin_r  input  1  serial input entering bit WIDTH-1 on shift right.
REQ-009 d  input  WIDTH  parallel load data.
REQ-010 q  output  WIDTH  register contents, registered.
REQ-011 sout_l  output  1  equals q[WIDTH-1], the bit lost on the next left shift; combinational from q.
REQ-012 sout_r  output  1  equals q[0], the bit lost on the next right shift; combinational from q.
REQ-013 cnt  output  $clog2(WIDTH+1)  number of shifts since the last load or reset, registered.
REQ-014 full  output  1  asserted when cnt == WIDTH, registered.

Function
REQ-015 Latency: every operation SHALL take effect on q, cnt and full at the first rising clk edge where en=1; there are no wait states.
REQ-016 mode=00 with en=1 SHALL leave q, cnt and full unchanged.
REQ-017 mode=01 SHALL set q <= {q[WIDTH-2:0], sin_l}.
REQ-018 mode=10 SHALL set q <= {sin_r, q[WIDTH-1:1]}.
REQ-019 mode=11 SHALL set q <= d and cnt <= 0.
REQ-020 Each left or right shift SHALL increment cnt by 1, saturating at WIDTH; once saturated, further shifts SHALL leave cnt at WIDTH.
REQ-021 full SHALL equal (next cnt == WIDTH) and be updated in the same cycle as cnt; it SHALL never be asserted while cnt < WIDTH.
REQ-022 en=0 SHALL hold q, cnt and full regardless of mode, sin_l, sin_r and d.
REQ-023 Simultaneous reset and en=1 with any mode: reset SHALL take priority.

Reset
REQ-024 When reset=1 at a rising clk edge, the block SHALL set q <= RESET_VAL, cnt <= 0 and full <= 0, independent of en and mode.
REQ-025 Reset asserted mid-sequence SHALL discard any partial shift count; no operation is pending after reset.
REQ-026 Before the first reset edge, output values are don't-care to the bench.

Configuration
REQ-027 Macro USR_ROTATE_EN, when defined, SHALL add an input port rot (1 bit).
REQ-028 With USR_ROTATE_EN defined and rot=1:
  - mode=01 SHALL rotate left, q <= {q[WIDTH-2:0], q[WIDTH-1]};
  - mode=10 SHALL rotate right, q <= {q[0], q[WIDTH-1:1]};
  - cnt and full SHALL be unchanged;
  - rot SHALL be ignored in modes 00 and 11.
REQ-029 Without USR_ROTATE_EN, the rot port SHALL be absent and behaviour SHALL match REQ-016..REQ-023 exactly.

Structure
REQ-030 Package usr_pkg SHALL hold:
  - typedef usr_mode_t (2-bit enum: USR_HOLD, USR_SHL, USR_SHR, USR_LOAD);
  - any shared width-helper functions.
REQ-031 The saturating shift counter SHALL be a separate sub-module, usr_sat_cnt.
REQ-032 usr_sat_cnt SHALL take parameter MAX and inputs clear, inc and clk/reset, and SHALL produce cnt and full outputs.

Verification (WIDTH=8, RESET_VAL=0)
REQ-033 Reset: reset=1 for 2 cycles with en=1, mode=11, d=A5 -> q=00, cnt=0, full=0.
REQ-034 Load then shift left: load A5, then mode=01, sin_l=1 -> sout_l=1 before the shift, q=4B and cnt=1 after it.
REQ-035 Fill and saturate: from q=00, 9 right shifts with sin_r=1 -> q=FF after shift 8; cnt steps 1..8; full=1 from shift 8; cnt stays 8 and full stays 1 after shift 9.
REQ-036 Enable and hold: q=3C, en=0 with mode=01 for 3 cycles, then en=1 with mode=00 -> q=3C and cnt unchanged throughout.
REQ-037 Reset priority: after 4 shifts (cnt=4), reset=1 together with en=1, mode=11, d=FF -> q=00, cnt=0, full=0.
REQ-038 USR_ROTATE_EN: load 81, then rot=1, mode=01 -> q=03, cnt=0; then mode=10 -> q=81, cnt=0.
